ifetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction memory. It owns the program counter and drives the memory's request/address pins, and it absorbs the memory's one-cycle synchronous read latency. Fetched words pass to decode through a 2-entry output FIFO with valid/ready handshake. Redirects (branch, jump, trap) flush all in-flight work; misaligned targets produce a fault entry instead of a fetch.

---
 rtl/ifetch_unit.sv | 135 +++++++++++++
 tb/tb_ifetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency reads to the
// instruction memory and queues fetched words for decode in a 2-entry FIFO.
package memory_pkg;
    localparam logic [31:0] MAP_IMEM_BASE = 32'h0000_0000;
endpackage

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = memory_pkg::MAP_IMEM_BASE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    typedef enum logic {RUN, HALT} fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [31:0] pc_q;
    logic [31:0] inflight_pc_q;
    logic        inflight_q;
    logic [1:0]  count_q;

    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        fifo_fault [2];

    logic        pop;
    logic        issue;
    logic        fault_push;
    logic        resp_push;
    logic        push;
    logic        space;
    logic        aligned;
    logic [2:0]  occupancy;
    logic [1:0]  level;
    logic [31:0] push_instr;
    logic [31:0] push_pc;

    assign instr_valid_o = (count_q != 2'd0);
    assign instr_o       = instr_valid_o ? fifo_instr[0] : 32'h0;
    assign pc_o          = instr_valid_o ? fifo_pc[0]    : 32'h0;
    assign fault_o       = instr_valid_o & fifo_fault[0];

    assign pop       = instr_valid_o & instr_ready_i;
    // level: entries left after this cycle's pop; also the slot a push lands in
    assign level     = count_q - {1'b0, pop};
    assign occupancy = {1'b0, level} + {2'b00, inflight_q};
    assign space     = (occupancy < 3'd2);
    assign aligned   = (pc_q[1:0] == 2'b00);

    always_comb begin
        fsm_d      = fsm_q;
        issue      = 1'b0;
        fault_push = 1'b0;
        if (redirect_i) begin
            fsm_d = RUN;
        end else begin
            case (fsm_q)
                RUN: begin
                    if (aligned) begin
                        issue = space;
                    end else if (!inflight_q && !level[1]) begin
                        fault_push = 1'b1;
                        fsm_d      = HALT;
                    end
                end
                HALT:    ;
                default: ;
            endcase
        end
    end

    // Request pins stay quiet while reset is held even though pc_q is valid.
    assign imem_req_o  = issue & rst_i;
    assign imem_addr_o = pc_q;

    assign resp_push  = inflight_q & ~redirect_i;
    assign push       = resp_push | fault_push;
    assign push_instr = fault_push ? 32'h0 : imem_instr_i;
    assign push_pc    = fault_push ? pc_q  : inflight_pc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fsm_q      <= RUN;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            fsm_q <= fsm_d;
            if (redirect_i) begin
                pc_q       <= redirect_pc_i;
                inflight_q <= 1'b0;
                count_q    <= 2'd0;
            end else begin
                inflight_q <= issue;
                if (issue) begin
                    pc_q <= pc_q + 32'd4;
                end
                count_q <= level + {1'b0, push};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) begin
            inflight_pc_q <= pc_q;
        end
    end

    // Shift-style FIFO: slot 0 is always the head; a push after a pop wins slot 0.
    always_ff @(posedge clk_i) begin
        if (!redirect_i) begin
            if (pop) begin
                fifo_instr[0] <= fifo_instr[1];
                fifo_pc[0]    <= fifo_pc[1];
                fifo_fault[0] <= fifo_fault[1];
            end
            if (push) begin
                fifo_instr[level[0]] <= push_instr;
                fifo_pc[level[0]]    <= push_pc;
                fifo_fault[level[0]] <= fault_push;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed table-driven bench for ifetch_unit with a one-cycle-latency memory model.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        efault;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .pc_o          (pc),
        .fault_o       (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            default: return a ^ 32'h1357_0000;
        endcase
    endfunction

    // Read data is garbage whenever no request was made the cycle before.
    always @(posedge clk) begin
        imem_instr <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                       input logic ef, input logic eq, input logic [31:0] ea);
        vec_t v;
        v.ready = r; v.redir = rd; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.einstr = ei; v.efault = ef;
        v.ereq = eq; v.eaddr = ea;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " valid"}, {31'b0, instr_valid}, {31'b0, v.ev});
        check({tag, " pc"},    pc,                   v.epc);
        check({tag, " instr"}, instr,                v.einstr);
        check({tag, " fault"}, {31'b0, fault},       {31'b0, v.efault});
        check({tag, " req"},   {31'b0, imem_req},    {31'b0, v.ereq});
        check({tag, " addr"},  imem_addr,            v.eaddr);
    endtask

    initial begin
        vec_t v;
        rst_i       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;

        // ready, redir, rpc, valid, pc, instr, fault, req, addr
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h4);
        for (int i = 0; i < 10; i++)
            add(0, 0, 32'h0, 1, 32'h0, 32'h0000_0013, 0, 0, 32'h8);
        add(1, 0, 32'h0, 1, 32'h0, 32'h0000_0013, 0, 1, 32'h8);
        add(1, 0, 32'h0, 1, 32'h4, 32'h0010_0093, 0, 1, 32'hC);
        add(1, 0, 32'h0, 1, 32'h8, 32'h0020_0113, 0, 1, 32'h10);
        add(1, 0, 32'h0, 1, 32'hC, 32'h1357_000C, 0, 1, 32'h14);
        add(0, 1, 32'h40, 1, 32'h10, 32'h1357_0010, 0, 0, 32'h18);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h40);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h44);
        add(1, 0, 32'h0, 1, 32'h40, 32'h1357_0040, 0, 1, 32'h48);
        add(1, 1, 32'h42, 1, 32'h44, 32'h1357_0044, 0, 0, 32'h4C);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h42);
        add(0, 0, 32'h0, 1, 32'h42, 32'h0, 1, 0, 32'h42);
        add(1, 0, 32'h0, 1, 32'h42, 32'h0, 1, 0, 32'h42);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h42);
        add(1, 1, 32'h80, 0, 32'h0, 32'h0, 0, 0, 32'h42);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h80);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h84);
        add(1, 0, 32'h0, 1, 32'h80, 32'h1357_0080, 0, 1, 32'h88);
        add(1, 1, 32'hFFFF_FFF8, 1, 32'h84, 32'h1357_0084, 0, 0, 32'h8C);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'hFFFF_FFF8);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        add(1, 0, 32'h0, 1, 32'hFFFF_FFF8, 32'hECA8_FFF8, 0, 1, 32'h0);
        add(1, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hECA8_FFFC, 0, 1, 32'h4);
        add(0, 0, 32'h0, 1, 32'h0, 32'h0000_0013, 0, 0, 32'h8);
        add(0, 0, 32'h0, 1, 32'h0, 32'h0000_0013, 0, 0, 32'h8);

        // Reset state while held.
        repeat (3) @(posedge clk);
        #1;
        v = '{ready: 0, redir: 0, rpc: 0, ev: 0, epc: 0, einstr: 0, efault: 0, ereq: 0, eaddr: 32'h0};
        check_outputs("reset", v);

        rst_i = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            instr_ready = vecs[i].ready;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            #2;
            check_outputs($sformatf("row%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end

        // Mid-stream async reset with two entries queued.
        redirect = 1'b0;
        check("pre_rst valid", {31'b0, instr_valid}, 32'h1);
        rst_i = 1'b0;
        #1;
        check("rst valid", {31'b0, instr_valid}, 32'h0);
        check("rst pc",    pc,                   32'h0);
        check("rst instr", instr,                32'h0);
        check("rst fault", {31'b0, fault},       32'h0);
        check("rst req",   {31'b0, imem_req},    32'h0);
        // A redirect during reset must not move the restart address.
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(posedge clk);
        #1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        rst_i       = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("restart req",   {31'b0, imem_req},    32'h1);
        check("restart addr",  imem_addr,            32'h0);
        check("restart valid", {31'b0, instr_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("restart addr2",  imem_addr,            32'h4);
        check("restart valid2", {31'b0, instr_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("restart valid3", {31'b0, instr_valid}, 32'h1);
        check("restart pc3",    pc,                   32'h0);
        check("restart instr3", instr,                32'h0000_0013);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
